capturador_dd: RTL and testbench

- Camera-side capture block for the OV7670 path.
- Samples the RGB565 byte stream (D, HREF, VSYNC) on PCLK and packs each pixel to RGB332.
- Emits one write (data/addr/regwrite) per pixel into the write port of the dual-port frame buffer.
- A frame is captured only on request (CBtn); the VGA side reads the buffer independently.

---
 rtl/capturador_dd.sv | 175 +++++++++++++++++
 tb/tb_capturador_dd.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capturador_dd.sv
// ============================================================================
// capturador_dd -- OV7670 capture block for the frame-buffer write port
//
// Samples the RGB565 byte stream from the camera on PCLK and packs each
// pixel to RGB332. Every pixel inside the CAM_SCREEN_X x CAM_SCREEN_Y window
// produces one write (data/addr/regwrite) into the dual-port frame buffer.
// A frame is captured only when requested with CBtn.
//
// Ports:
//   PCLK      in   camera pixel clock; the only clock, rising edge
//   rst       in   asynchronous, active-low reset
//   VSYNC     in   vertical sync, high between frames
//   HREF      in   line valid, high while line bytes are present
//   D[7:0]    in   camera data byte
//   CBtn      in   capture request (level, synchronous to PCLK)
//   data      out  RGB332 pixel to the frame buffer
//   addr      out  linear frame-buffer address
//   regwrite  out  write strobe, one PCLK per stored pixel
//
// Build option:
//   CAPTURE_CONTINUOUS_EN  when defined, CBtn is ignored and every frame is
//                          captured (live video); when undefined, one frame
//                          is captured per CBtn request.
// ============================================================================
module capturador_dd #(
    parameter int CAM_SCREEN_X = 180,
    parameter int CAM_SCREEN_Y = 120,
    parameter int AW           = 15,
    parameter int DW           = 8
) (
    input  logic          PCLK,
    input  logic          rst,
    input  logic          VSYNC,
    input  logic          HREF,
    input  logic [7:0]    D,
    input  logic          CBtn,
    output logic [DW-1:0] data,
    output logic [AW-1:0] addr,
    output logic          regwrite
);

    // Counters need one extra code so they can saturate at the window limit.
    localparam int XW = $clog2(CAM_SCREEN_X + 1);
    localparam int YW = $clog2(CAM_SCREEN_Y + 1);

    localparam logic [XW-1:0] X_LIM = XW'(CAM_SCREEN_X);
    localparam logic [YW-1:0] Y_LIM = YW'(CAM_SCREEN_Y);
    localparam logic [AW-1:0] X_AW  = AW'(CAM_SCREEN_X);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        SYNC    = 2'd2,
        CAPTURE = 2'd3
    } state_t;

`ifdef CAPTURE_CONTINUOUS_EN
    // Live video: always armed, and each frame end immediately waits for the
    // next frame start.
    localparam state_t RESET_STATE     = ARMED;
    localparam state_t FRAME_END_STATE = SYNC;
`else
    localparam state_t RESET_STATE     = IDLE;
    localparam state_t FRAME_END_STATE = IDLE;
`endif

    state_t          state_reg;
    logic [XW-1:0]   x_reg;
    logic [YW-1:0]   y_reg;
    logic            phase_reg;      // 0: expecting hi byte, 1: expecting lo byte
    logic [7:0]      hi_reg;
    logic            href_d_reg;     // HREF one cycle ago, for falling-edge detect
    logic [DW-1:0]   data_reg;
    logic [AW-1:0]   addr_reg;
    logic            regwrite_reg;

    logic [AW-1:0]   pix_addr;
    logic            in_window;
    logic [7:0]      pix_rgb332;

    // Counters saturate at the window limits, so this AW-bit product can never
    // wrap; writes are further gated by in_window so the limit address itself
    // (reserved for the display's out-of-window pixel) is never produced.
    assign pix_addr   = AW'(y_reg) * X_AW + AW'(x_reg);
    assign in_window  = (x_reg < X_LIM) && (y_reg < Y_LIM);
    // RRRRRGGG / GGGBBBBB -> RRRGGGBB
    assign pix_rgb332 = {hi_reg[7:5], hi_reg[2:0], D[4:3]};

    always_ff @(posedge PCLK or negedge rst) begin
        if (!rst) begin
            state_reg    <= RESET_STATE;
            x_reg        <= '0;
            y_reg        <= '0;
            phase_reg    <= 1'b0;
            hi_reg       <= '0;
            href_d_reg   <= 1'b0;
            data_reg     <= '0;
            addr_reg     <= '0;
            regwrite_reg <= 1'b0;
        end else begin
            regwrite_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
`ifdef CAPTURE_CONTINUOUS_EN
                    state_reg <= ARMED;
`else
                    if (CBtn) begin
                        state_reg <= ARMED;
                    end
`endif
                end

                // Wait for the inter-frame gap so capture never starts mid-frame.
                ARMED: begin
                    if (VSYNC) begin
                        state_reg <= SYNC;
                    end
                end

                SYNC: begin
                    if (!VSYNC) begin
                        state_reg  <= CAPTURE;
                        x_reg      <= '0;
                        y_reg      <= '0;
                        phase_reg  <= 1'b0;
                        href_d_reg <= 1'b0;
                    end
                end

                CAPTURE: begin
                    if (VSYNC) begin
                        // Frame over (complete or partial); any half pixel is dropped.
                        state_reg  <= FRAME_END_STATE;
                        phase_reg  <= 1'b0;
                        href_d_reg <= 1'b0;
                    end else begin
                        href_d_reg <= HREF;
                        if (HREF) begin
                            phase_reg <= ~phase_reg;
                            if (!phase_reg) begin
                                hi_reg <= D;
                            end else begin
                                // data/addr only move on a real write so they hold otherwise.
                                if (in_window) begin
                                    data_reg     <= DW'(pix_rgb332);
                                    addr_reg     <= pix_addr;
                                    regwrite_reg <= 1'b1;
                                end
                                if (x_reg != X_LIM) begin
                                    x_reg <= x_reg + XW'(1);
                                end
                            end
                        end else begin
                            phase_reg <= 1'b0;
                            if (href_d_reg) begin
                                // x > 0 means this line produced at least one pixel.
                                x_reg <= '0;
                                if ((x_reg != '0) && (y_reg != Y_LIM)) begin
                                    y_reg <= y_reg + YW'(1);
                                end
                            end
                        end
                    end
                end

                default: state_reg <= RESET_STATE;
            endcase
        end
    end

    assign data     = data_reg;
    assign addr     = addr_reg;
    assign regwrite = regwrite_reg;

endmodule

// File: tb/tb_capturador_dd.sv
// ============================================================================
// tb_capturador_dd -- directed self-checking bench for capturador_dd
//
// A monitor logs every write strobe (sampled on the falling PCLK edge);
// scenario tasks drive the camera stream on falling edges and compare the
// observed outputs / write log against hand-derived values.
// Build with +define+CAPTURE_CONTINUOUS_EN to exercise the live-video option.
// ============================================================================
`timescale 1ns/1ps
module tb_capturador_dd;

    localparam int X    = 180;
    localparam int Y    = 120;
    localparam int AW   = 15;
    localparam int DW   = 8;
    localparam int NPIX = X * Y;
    localparam int LOGN = 32768;

    logic          PCLK = 1'b0;
    logic          rst;
    logic          VSYNC;
    logic          HREF;
    logic [7:0]    D;
    logic          CBtn;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic          regwrite;

    int checks   = 0;
    int failures = 0;

    int            wcount = 0;
    logic [AW-1:0] wlog_addr [0:LOGN-1];
    logic [7:0]    wlog_data [0:LOGN-1];

    always #5 PCLK = ~PCLK;

    capturador_dd #(
        .CAM_SCREEN_X (X),
        .CAM_SCREEN_Y (Y),
        .AW           (AW),
        .DW           (DW)
    ) dut (
        .PCLK     (PCLK),
        .rst      (rst),
        .VSYNC    (VSYNC),
        .HREF     (HREF),
        .D        (D),
        .CBtn     (CBtn),
        .data     (data),
        .addr     (addr),
        .regwrite (regwrite)
    );

    // Write monitor
    always @(negedge PCLK) begin
        if (regwrite === 1'b1) begin
            if (wcount < LOGN) begin
                wlog_addr[wcount] = addr;
                wlog_data[wcount] = data;
            end
            wcount++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic h, input logic [7:0] b);
        @(negedge PCLK);
        HREF = h;
        D    = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
    endtask

    // VSYNC high for a few cycles, then low: frame start.
    task automatic frame_start();
        @(negedge PCLK);
        HREF  = 1'b0;
        VSYNC = 1'b1;
        idle(3);
        @(negedge PCLK);
        VSYNC = 1'b0;
        idle(2);
    endtask

    task automatic frame_end();
        @(negedge PCLK);
        HREF  = 1'b0;
        VSYNC = 1'b1;
        idle(2);
    endtask

    // Byte pair whose RGB332 packing is v.
    task automatic send_pix(input logic [7:0] v);
        logic [7:0] hi;
        logic [7:0] lo;
        hi = {v[7:5], 2'b00, v[4:2]};
        lo = {3'b000, v[1:0], 3'b000};
        drive(1'b1, hi);
        drive(1'b1, lo);
    endtask

    task automatic pulse_cbtn();
        @(negedge PCLK);
        CBtn = 1'b1;
        @(negedge PCLK);
        CBtn = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge PCLK);
        rst   = 1'b0;
        VSYNC = 1'b0;
        HREF  = 1'b0;
        D     = 8'h00;
        CBtn  = 1'b0;
        idle(2);
        @(negedge PCLK);
        rst = 1'b1;
        idle(1);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            VSYNC = 1'($urandom_range(0, 1));
            HREF  = 1'($urandom_range(0, 1));
            D     = 8'($urandom_range(0, 255));
            CBtn  = 1'($urandom_range(0, 1));
            checks++;
            if (regwrite !== 1'b0) begin
                failures++;
                $display("FAIL reset_regwrite got=%b exp=0", regwrite);
            end
            checks++;
            if (addr !== '0) begin
                failures++;
                $display("FAIL reset_addr got=%0d exp=0", addr);
            end
            checks++;
            if (data !== '0) begin
                failures++;
                $display("FAIL reset_data got=%0h exp=0", data);
            end
        end
        @(negedge PCLK);
        VSYNC = 1'b0;
        HREF  = 1'b0;
        CBtn  = 1'b0;
        rst   = 1'b1;
        wcount = 0;
`ifndef CAPTURE_CONTINUOUS_EN
        // Full frame traffic without a request must not write anything.
        frame_start();
        for (int i = 0; i < 4; i++) send_pix(8'(i + 1));
        idle(1);
        frame_end();
        idle(2);
        checks++;
        if (wcount !== 0) begin
            failures++;
            $display("FAIL no_write_without_cbtn got=%0d exp=0", wcount);
        end
`endif
        $display("test_reset: done, writes=%0d", wcount);
    endtask

`ifndef CAPTURE_CONTINUOUS_EN
    task automatic test_single_pixel();
        wcount = 0;
        pulse_cbtn();
        frame_start();
        drive(1'b1, 8'hF8);
        drive(1'b1, 8'h1F);
        drive(1'b1, 8'h07);   // first write visible here
        checks++;
        if (regwrite !== 1'b1 || data !== 8'hE3 || addr !== 15'd0) begin
            failures++;
            $display("FAIL pix0 got we=%b data=%0h addr=%0d exp we=1 data=e3 addr=0",
                     regwrite, data, addr);
        end
        drive(1'b1, 8'hE0);
        checks++;
        if (regwrite !== 1'b0 || data !== 8'hE3) begin
            failures++;
            $display("FAIL pulse_width got we=%b data=%0h exp we=0 data=e3", regwrite, data);
        end
        drive(1'b1, 8'hFF);   // odd trailing byte
        checks++;
        if (regwrite !== 1'b1 || data !== 8'h1C || addr !== 15'd1) begin
            failures++;
            $display("FAIL pix1 got we=%b data=%0h addr=%0d exp we=1 data=1c addr=1",
                     regwrite, data, addr);
        end
        drive(1'b0, 8'h00);
        idle(2);
        checks++;
        if (wcount !== 2) begin
            failures++;
            $display("FAIL odd_byte_dropped got=%0d exp=2", wcount);
        end
        checks++;
        if (data !== 8'h1C || addr !== 15'd1) begin
            failures++;
            $display("FAIL hold got data=%0h addr=%0d exp data=1c addr=1", data, addr);
        end
        drive(1'b1, 8'hFF);
        drive(1'b1, 8'hFF);
        drive(1'b0, 8'h00);
        checks++;
        if (regwrite !== 1'b1 || addr !== 15'd180 || data !== 8'hFF) begin
            failures++;
            $display("FAIL line1_start got we=%b addr=%0d data=%0h exp we=1 addr=180 data=ff",
                     regwrite, addr, data);
        end
        idle(2);
        frame_end();
        idle(2);
        $display("test_single_pixel: done, writes=%0d", wcount);
    endtask

    task automatic test_gating();
        wcount = 0;
        // Request arrives in the middle of a frame already in progress.
        @(negedge PCLK);
        VSYNC = 1'b0;
        idle(2);
        send_pix(8'h11);
        @(negedge PCLK);
        HREF = 1'b1;
        D    = 8'h22;
        CBtn = 1'b1;
        @(negedge PCLK);
        D    = 8'h33;
        CBtn = 1'b0;
        send_pix(8'h44);
        drive(1'b0, 8'h00);
        idle(2);
        checks++;
        if (wcount !== 0) begin
            failures++;
            $display("FAIL no_midframe_start got=%0d exp=0", wcount);
        end
        frame_start();
        send_pix(8'h5A);
        drive(1'b0, 8'h00);
        idle(1);
        checks++;
        if (wcount !== 1 || wlog_addr[0] !== 15'd0 || wlog_data[0] !== 8'h5A) begin
            failures++;
            $display("FAIL first_after_vsync got n=%0d addr=%0d data=%0h exp n=1 addr=0 data=5a",
                     wcount, wlog_addr[0], wlog_data[0]);
        end
        // VSYNC rises in the middle of a line: the half pixel and the rest are lost.
        drive(1'b1, 8'hE0);
        @(negedge PCLK);
        VSYNC = 1'b1;
        D     = 8'h18;
        for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h30 + i));
        drive(1'b0, 8'h00);
        @(negedge PCLK);
        VSYNC = 1'b0;
        idle(2);
        send_pix(8'h66);
        send_pix(8'h77);
        drive(1'b0, 8'h00);
        idle(2);
        checks++;
        if (wcount !== 1) begin
            failures++;
            $display("FAIL vsync_abort got=%0d exp=1", wcount);
        end
        // Reset in the middle of a line.
        wcount = 0;
        pulse_cbtn();
        frame_start();
        send_pix(8'h11);
        send_pix(8'h22);
        @(posedge PCLK);
        #1;
        checks++;
        if (regwrite !== 1'b1 || addr !== 15'd1 || data !== 8'h22) begin
            failures++;
            $display("FAIL pre_abort got we=%b addr=%0d data=%0h exp we=1 addr=1 data=22",
                     regwrite, addr, data);
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (regwrite !== 1'b0 || addr !== '0 || data !== '0) begin
            failures++;
            $display("FAIL async_reset got we=%b addr=%0d data=%0h exp all 0",
                     regwrite, addr, data);
        end
        @(negedge PCLK);
        rst = 1'b1;
        send_pix(8'h33);
        drive(1'b0, 8'h00);
        frame_start();
        send_pix(8'h44);
        drive(1'b0, 8'h00);
        idle(2);
        checks++;
        if (wcount !== 1) begin
            failures++;
            $display("FAIL idle_after_reset got=%0d exp=1", wcount);
        end
        $display("test_gating: done, writes=%0d", wcount);
    endtask
`else
    task automatic test_continuous();
        reset_dut();
        wcount = 0;
        CBtn   = 1'b0;
        frame_start();
        send_pix(8'h10); send_pix(8'h20); send_pix(8'h30);
        drive(1'b0, 8'h00);
        send_pix(8'h40); send_pix(8'h50); send_pix(8'h60);
        drive(1'b0, 8'h00);
        frame_start();
        send_pix(8'h70); send_pix(8'h80);
        drive(1'b0, 8'h00);
        idle(2);
        checks++;
        if (wcount !== 8) begin
            failures++;
            $display("FAIL cont_count got=%0d exp=8", wcount);
        end
        checks++;
        if (wlog_addr[0] !== 15'd0 || wlog_data[0] !== 8'h10) begin
            failures++;
            $display("FAIL cont_first got addr=%0d data=%0h exp addr=0 data=10",
                     wlog_addr[0], wlog_data[0]);
        end
        checks++;
        if (wlog_addr[3] !== 15'd180 || wlog_data[3] !== 8'h40) begin
            failures++;
            $display("FAIL cont_line1 got addr=%0d data=%0h exp addr=180 data=40",
                     wlog_addr[3], wlog_data[3]);
        end
        checks++;
        if (wlog_addr[6] !== 15'd0 || wlog_data[6] !== 8'h70) begin
            failures++;
            $display("FAIL cont_frame2 got addr=%0d data=%0h exp addr=0 data=70",
                     wlog_addr[6], wlog_data[6]);
        end
        checks++;
        if (wlog_addr[7] !== 15'd1 || wlog_data[7] !== 8'h80) begin
            failures++;
            $display("FAIL cont_frame2_pix1 got addr=%0d data=%0h exp addr=1 data=80",
                     wlog_addr[7], wlog_data[7]);
        end
        $display("test_continuous: done, writes=%0d", wcount);
    endtask
`endif

    // Oversized frame: 130 lines of 200 pixels plus an odd byte per line.
    task automatic test_frame();
        int bad_range;
        int bad_lines;
        int bad_data;
        reset_dut();
        wcount = 0;
        pulse_cbtn();
        frame_start();
        for (int yy = 0; yy < 130; yy++) begin
            for (int xx = 0; xx < 200; xx++) begin
                if (xx < X && yy < Y) send_pix(8'((yy * X + xx) & 255));
                else                  send_pix(8'h55);
            end
            drive(1'b1, 8'hAA);
            drive(1'b0, 8'h00);
        end
        frame_end();
        idle(2);
        checks++;
        if (wcount !== NPIX) begin
            failures++;
            $display("FAIL frame_count got=%0d exp=%0d", wcount, NPIX);
        end
        checks++;
        if (wcount < 1 || wcount > LOGN || wlog_addr[wcount-1] !== 15'(NPIX - 1)) begin
            failures++;
            $display("FAIL frame_last_addr got=%0d exp=%0d",
                     (wcount >= 1 && wcount <= LOGN) ? int'(wlog_addr[wcount-1]) : -1,
                     NPIX - 1);
        end
        bad_range = 0;
        bad_data  = 0;
        for (int i = 0; i < wcount && i < LOGN; i++) begin
            if (int'(wlog_addr[i]) >= NPIX) bad_range++;
            if (wlog_data[i] !== 8'(i & 255)) bad_data++;
        end
        checks++;
        if (bad_range !== 0) begin
            failures++;
            $display("FAIL frame_addr_range got=%0d out-of-range writes exp=0", bad_range);
        end
        checks++;
        if (bad_data !== 0) begin
            failures++;
            $display("FAIL frame_data got=%0d bad pixels exp=0", bad_data);
        end
        bad_lines = 0;
        for (int k = 0; k < Y; k++) begin
            if (k * X >= wcount || wlog_addr[k * X] !== 15'(k * X)) bad_lines++;
        end
        checks++;
        if (bad_lines !== 0) begin
            failures++;
            $display("FAIL frame_line_start got=%0d bad lines exp=0", bad_lines);
        end
        $display("test_frame: done, writes=%0d", wcount);
    endtask

    initial begin
        rst   = 1'b0;
        VSYNC = 1'b0;
        HREF  = 1'b0;
        D     = 8'h00;
        CBtn  = 1'b0;
        test_reset();
`ifndef CAPTURE_CONTINUOUS_EN
        test_single_pixel();
        test_gating();
`else
        test_continuous();
`endif
        test_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
